// File: rtl/mips32_pkg.sv
// Shared MIPS32 memory-interface types and constants used by the core and the
// data-memory responder.
package mips32_pkg;

  localparam int DEF_MEM_WORDS = 1024;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/mips32_rsp_fifo.sv
// First-word-fall-through response FIFO: head is valid whenever empty is low.
// The caller guarantees no push when full and no pop when empty.
module mips32_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips32_dmem_responder.sv
// Word-addressed data memory for the MIPS32 load/store port: fixed-latency
// read pipeline feeding an in-order response FIFO, with credit-based req_ready.
module mips32_dmem_responder
  import mips32_pkg::*;
#(
  parameter int MEM_WORDS  = DEF_MEM_WORDS,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; a source holds valid and its payload stable until that edge.
  logic [31:0]        mem [MEM_WORDS];
  logic [CW-1:0]      outstanding;
  logic               accept;
  logic               pop;
  logic               in_range;
  logic [LATENCY-1:0] pipe_vld;
  rsp_t               pipe_rsp [LATENCY];
  rsp_t               head;
  logic               fifo_full;
  logic               fifo_empty;

  assign in_range  = (req_addr < 32'(MEM_WORDS));
  assign req_ready = !rst && (outstanding < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? head.rdata : '0;
  assign rsp_err   = rsp_valid && head.err;
  assign busy      = (outstanding != '0);

  // Storage is never reset, so stores accepted before a reset stay committed.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range) mem[req_addr[AW-1:0]] <= req_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_rsp[i] <= '0;
    end else begin
      pipe_vld[0]       <= accept;
      pipe_rsp[0].err   <= !in_range;
      pipe_rsp[0].rdata <= (!req_we && in_range) ? mem[req_addr[AW-1:0]] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_rsp[i] <= pipe_rsp[i-1];
      end
    end
  end

  // Outstanding counts the pipeline and FIFO together, so the FIFO cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  mips32_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (RSP_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_vld[LATENCY-1]),
    .push_data (pipe_rsp[LATENCY-1]),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pipe_vld[LATENCY-1] && fifo_full));

endmodule

// File: tb/tb_mips32_dmem_responder.sv
// Bench for mips32_dmem_responder: directed scenarios plus randomized traffic,
// all responses scored against a word-array memory model and expected queue.
module tb_mips32_dmem_responder;

  localparam int MEM_WORDS  = 1024;
  localparam int LATENCY    = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] ref_mem [MEM_WORDS];
  logic [32:0] exp_q[$];
  int          acc_cyc_q[$];
  int          pop_cyc_q[$];
  logic        hold_pend = 1'b0;
  logic [32:0] hold_val;
  logic        rnd_on;

  mips32_dmem_responder #(
    .MEM_WORDS  (MEM_WORDS),
    .LATENCY    (LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk1),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: inputs are stable from posedge+1 to the next posedge, so what is
  // seen here is what the coming edge will transfer
  always @(negedge clk1) begin : mon
    logic [32:0] e;
    logic        inr;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      check("busy", busy, exp_q.size() != 0);
      check("req_ready", req_ready, exp_q.size() < FIFO_DEPTH);
      if (!rsp_valid) check("idle_rsp", {rsp_err, rsp_rdata}, 33'h0);
      if (hold_pend) check("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, hold_val});
      hold_pend = rsp_valid && !rsp_ready;
      hold_val  = {rsp_err, rsp_rdata};
      if (rsp_valid && rsp_ready) begin
        pop_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp_err, rsp_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", {rsp_err, rsp_rdata}, e);
        end
      end
      if (req_valid && req_ready) begin
        acc_cyc_q.push_back(cyc);
        inr = (req_addr < MEM_WORDS);
        if (req_we) begin
          if (inr) ref_mem[req_addr[9:0]] = req_wdata;
          exp_q.push_back({!inr, 32'h0});
        end else begin
          exp_q.push_back(inr ? {1'b0, ref_mem[req_addr[9:0]]} : {1'b1, 32'h0});
        end
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data);
    int budget = 200;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    @(negedge clk1);
    while (!req_ready && budget > 0) begin
      @(negedge clk1);
      budget--;
    end
    check("req_timeout", budget == 0, 0);
    @(posedge clk1);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 500;
    while ((exp_q.size() != 0 || busy) && budget > 0) begin
      @(negedge clk1);
      budget--;
    end
    check("drain_timeout", budget == 0, 0);
    @(posedge clk1);
    #1;
  endtask

  task automatic clear_stamps();
    acc_cyc_q.delete();
    pop_cyc_q.delete();
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; rnd_on = 1'b0;

    // reset held three cycles
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp", {rsp_err, rsp_rdata}, 33'h0);
    check("rst_busy", busy, 0);
    @(posedge clk1); #1 rst = 1'b0;
    @(negedge clk1);
    check("post_rst_ready", req_ready, 1);
    check("post_rst_busy", busy, 0);
    @(posedge clk1); #1;

    // read-after-write with exact latency
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'h1234_5678;
    @(posedge clk1); #1;
    req_we = 1'b0;
    @(posedge clk1); #1;
    req_valid = 1'b0;
    @(negedge clk1);
    check("raw_early", rsp_valid, 0);
    @(negedge clk1);
    check("raw_ack", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h0});
    @(negedge clk1);
    check("raw_load", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'h1234_5678});
    drain();

    // preload the low words so later loads never touch uninitialised storage
    for (int i = 0; i < 64; i++) send(1'b1, 32'(i), $urandom());
    drain();

    // out-of-range store and load, then address 0 must be untouched
    send(1'b1, 32'd1024, 32'h0000_DEAD);
    send(1'b0, 32'd1024, 32'h0);
    send(1'b0, 32'd0, 32'h0);
    drain();

    // backpressure: six loads against four credits
    clear_stamps();
    rsp_ready = 1'b0;
    fork
      for (int i = 0; i < 6; i++) send(1'b0, 32'(30 + i), 32'h0);
      begin
        repeat (10) @(negedge clk1);
        check("bp_accepted", acc_cyc_q.size(), 4);
        check("bp_req_ready", req_ready, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        @(posedge clk1); #1 rsp_ready = 1'b1;
      end
    join
    drain();
    check("bp_total", pop_cyc_q.size(), 6);

    // full throughput streaming
    clear_stamps();
    for (int i = 0; i < 20; i++) send(1'b0, 32'(i), 32'h0);
    drain();
    check("stream_acc_n", acc_cyc_q.size(), 20);
    check("stream_pop_n", pop_cyc_q.size(), 20);
    if (acc_cyc_q.size() == 20 && pop_cyc_q.size() == 20) begin
      check("stream_acc_gap", acc_cyc_q[19] - acc_cyc_q[0], 19);
      check("stream_pop_gap", pop_cyc_q[19] - pop_cyc_q[0], 19);
      check("stream_latency", pop_cyc_q[0] - acc_cyc_q[0], LATENCY + 1);
    end

    // randomized traffic with random response backpressure
    clear_stamps();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          r = $urandom_range(0, 9);
          if (r == 0)      addr = 32'(MEM_WORDS) + $urandom_range(0, 5000);
          else if (r == 1) addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
          else             addr = $urandom_range(0, 63);
          send($urandom_range(0, 9) < 4, addr, $urandom());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk1); #1;
          end
        end
        rnd_on = 1'b0;
      end
      while (rnd_on) begin
        @(posedge clk1); #1 rsp_ready = ($urandom_range(0, 9) < 7);
      end
    join
    rsp_ready = 1'b1;
    drain();
    check("rnd_count", pop_cyc_q.size(), 150);

    // reset with work in flight
    rsp_ready = 1'b0;
    send(1'b1, 32'd7, 32'h0000_CAFE);
    for (int i = 0; i < 3; i++) send(1'b0, 32'(10 + i), 32'h0);
    @(posedge clk1); #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0; rsp_ready = 1'b1;
    clear_stamps();
    repeat (8) @(negedge clk1);
    check("rst_no_stale", pop_cyc_q.size(), 0);
    @(posedge clk1); #1;
    send(1'b0, 32'd7, 32'h0);
    drain();
    check("rst_store_kept_n", pop_cyc_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
